// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter and its pin synchronizer.
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pm_state_e;

    // Matches the 26-bit counters used by the blink counter.
    localparam int PM_WIDTH       = 26;
    localparam int PM_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a rising-edge detector.
module sync_edge
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = PM_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic [SYNC_STAGES:0]   vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            s_d      <= 1'b0;
            vld_pipe <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            s_d      <= sync_q[SYNC_STAGES-1];
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];
    // A pin already high at reset release must not look like an edge against
    // the zeroed flops, so edges count only once s_d holds a real sample.
    assign rise = s & ~s_d & vld_pipe[SYNC_STAGES];

endmodule

// File: rtl/period_meter.sv
// Measures period and high time (in CLK cycles) of an asynchronous square wave,
// publishing each rise-to-rise interval with a one-cycle VALID strobe.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = PM_WIDTH,
    parameter int SYNC_STAGES = PM_SYNC_STAGES
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I,
    output logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] HIGH,
    output logic             VALID,
    output logic             TIMEOUT
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             s;
    logic             rise;
    logic [WIDTH-1:0] s_ext;

    pm_state_e        state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hcnt, hcnt_nxt;
    logic [WIDTH-1:0] period_nxt, high_nxt;
    logic             valid_nxt, timeout_nxt;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rst (RESET),
        .din (I),
        .s   (s),
        .rise(rise)
    );

    assign s_ext = {{(WIDTH-1){1'b0}}, s};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            hcnt    <= '0;
            PERIOD  <= '0;
            HIGH    <= '0;
            VALID   <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hcnt    <= hcnt_nxt;
            PERIOD  <= period_nxt;
            HIGH    <= high_nxt;
            VALID   <= valid_nxt;
            TIMEOUT <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hcnt_nxt    = hcnt;
        period_nxt  = PERIOD;
        high_nxt    = HIGH;
        valid_nxt   = 1'b0;
        timeout_nxt = TIMEOUT;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                hcnt_nxt = '0;
                if (rise) begin
                    state_nxt   = MEASURE;
                    cnt_nxt     = CNT_ONE;
                    hcnt_nxt    = s_ext;
                    timeout_nxt = 1'b0;
                end
            end
            MEASURE: begin
                // A rise on the saturating cycle still publishes normally.
                if (rise) begin
                    period_nxt = cnt;
                    high_nxt   = hcnt;
                    valid_nxt  = 1'b1;
                    cnt_nxt    = CNT_ONE;
                    hcnt_nxt   = CNT_ONE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    cnt_nxt     = '0;
                    hcnt_nxt    = '0;
                end else begin
                    cnt_nxt  = cnt + CNT_ONE;
                    hcnt_nxt = hcnt + s_ext;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                hcnt_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_period_meter.sv
// Randomized scoreboard bench for period_meter (WIDTH=8 so saturation is reachable).
module tb_period_meter;

    localparam int W    = 8;
    localparam int SS   = 2;
    localparam int MAXC = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         I;
    logic [W-1:0] PERIOD;
    logic [W-1:0] HIGH;
    logic         VALID;
    logic         TIMEOUT;

    int vectors = 0;
    int miscompares = 0;

    period_meter #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .I      (I),
        .PERIOD (PERIOD),
        .HIGH   (HIGH),
        .VALID  (VALID),
        .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks synchronized samples, rise times and the window of
    // samples since the last rise; results come from time differences and sums.
    typedef struct { int per; int high; } result_t;
    result_t exp_q[$];
    logic    syncm[SS];
    logic    s_d_m;
    int      nsamp, cyc, last_rise;
    bit      armed;
    int      win[$];
    int      exp_per, exp_high;
    bit      exp_to;

    always @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < SS; k++) syncm[k] = 1'b0;
            s_d_m = 1'b0; nsamp = 0; cyc = 0; last_rise = 0; armed = 0;
            win.delete(); exp_q.delete();
            exp_per = 0; exp_high = 0; exp_to = 0;
        end else begin
            logic s_now;
            bit   rise;
            s_now = syncm[SS-1];
            rise  = s_now && !s_d_m && (nsamp >= SS + 1);
            cyc++;
            if (rise) begin
                if (armed) begin
                    int sum;
                    result_t r;
                    sum = 0;
                    foreach (win[k]) sum += win[k];
                    r.per = cyc - last_rise;
                    r.high = sum;
                    exp_q.push_back(r);
                    exp_per = r.per;
                    exp_high = r.high;
                end
                armed = 1;
                exp_to = 0;
                last_rise = cyc;
                win.delete();
                win.push_back(1);
            end else if (armed) begin
                if (cyc - last_rise == MAXC) begin
                    armed = 0;
                    exp_to = 1;
                    win.delete();
                end else begin
                    win.push_back(int'(s_now));
                end
            end
            s_d_m = s_now;
            for (int k = SS - 1; k > 0; k--) syncm[k] = syncm[k-1];
            syncm[0] = I;
            nsamp++;
        end
    end

    // Monitor: decoupled from stimulus, compares outputs on the falling edge.
    always @(negedge CLK) begin
        if (RESET) begin
            check("reset_period", PERIOD, 0);
            check("reset_high", HIGH, 0);
            check("reset_valid", VALID, 0);
            check("reset_timeout", TIMEOUT, 0);
        end else begin
            check("valid", VALID, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                result_t r;
                r = exp_q.pop_front();
                if (VALID) begin
                    check("valid_period", PERIOD, r.per);
                    check("valid_high", HIGH, r.high);
                end
            end
            check("hold_period", PERIOD, exp_per);
            check("hold_high", HIGH, exp_high);
            check("timeout", TIMEOUT, exp_to);
        end
    end

    task automatic tick(input logic v);
        @(posedge CLK); #2;
        I = v;
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) tick(v);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic do_reset(input logic v);
        @(posedge CLK); #2;
        RESET = 1'b1;
        I = v;
        hold(v, 2);
        @(posedge CLK); #2;
        RESET = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        I = 1'b0;
        hold(1'b0, 4);
        @(posedge CLK); #2;
        RESET = 1'b0;

        wave(10, 10, 6);
        wave(3, 17, 4);
        wave(2, 2, 6);

        // two toggles then idle low long enough to saturate, then re-arm
        wave(5, 5, 2);
        hold(1'b0, 300);
        wave(10, 10, 3);

        // pin held high through reset: never arms
        do_reset(1'b1);
        hold(1'b1, 1000);

        // reset in the middle of a 20-cycle period
        hold(1'b0, 10);
        wave(10, 10, 3);
        hold(1'b1, 5);
        do_reset(1'b1);
        hold(1'b1, 3);
        hold(1'b0, 10);
        wave(10, 10, 4);

        // period exactly at, just below and just above the counter limit
        wave(100, 155, 4);
        wave(100, 154, 2);
        wave(100, 156, 3);

        repeat (40) wave($urandom_range(40, 2), $urandom_range(80, 2), 1);
        repeat (8) wave($urandom_range(30, 2), $urandom_range(300, 150), 1);

        hold(1'b0, 8);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
